// File: rtl/req_index_encoder8.sv
// Sticky request collector that hands out one pending index at a time on a valid/ready port.
// Define REQ_RR_ARB_EN for round-robin arbitration; otherwise the highest pending index wins.
module req_index_encoder8 #(
    parameter int REQ_W = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] req,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REQ_W-1:0] pending,
    output logic [IDX_W:0]   pend_cnt,
    output logic             ovf
);

    logic [REQ_W-1:0] pending_q;
    logic [REQ_W-1:0] pending_d;
    logic [IDX_W:0]   pendCnt_q;
    logic [IDX_W:0]   pendCnt_d;
    logic [IDX_W-1:0] outIdx_q;
    logic             outValid_q;
    logic             ovf_q;
    logic             ovf_d;
    logic [IDX_W-1:0] sel;
    logic [REQ_W-1:0] loadMask;
    logic             load;
    logic             hs;

`ifdef REQ_RR_ARB_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk forward from the slot after the last winner; k=REQ_W wraps back onto ptr itself.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= REQ_W; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!found && pending_q[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '1;
        end else if (load) begin
            ptr_q <= sel;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = 0; i < REQ_W; i++) begin
            if (pending_q[i]) begin
                sel = IDX_W'(i);
            end
        end
    end
`endif

    assign hs   = outValid_q & out_ready;
    assign load = (!outValid_q | out_ready) & (|pending_q);

    // A strobe on the bit being loaded this cycle re-arms it rather than counting as overflow.
    always_comb begin
        loadMask = '0;
        if (load) begin
            loadMask[sel] = 1'b1;
        end
        pending_d = (pending_q & ~loadMask) | req;
        ovf_d     = ovf_q | (|(req & pending_q & ~loadMask));
        pendCnt_d = (IDX_W+1)'($countones(pending_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            pendCnt_q  <= '0;
            ovf_q      <= 1'b0;
            outIdx_q   <= '0;
            outValid_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            pendCnt_q <= pendCnt_d;
            ovf_q     <= ovf_d;
            if (load) begin
                outIdx_q   <= sel;
                outValid_q <= 1'b1;
            end else if (hs) begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign out_idx   = outIdx_q;
    assign out_valid = outValid_q;
    assign pending   = pending_q;
    assign pend_cnt  = pendCnt_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/req_index_encoder8.md
Name: req_index_encoder8

Overview:
- Upstream feeder for the 3-to-8 decoder stage.
- Captures up to 8 single-cycle request strobes into a sticky pending register.
- Selects one pending request at a time and presents its 3-bit index on a valid/ready output.
- The downstream decoder turns the accepted index back into one-hot form.

Parameters:
- REQ_W, 8, number of request lines; must equal 2**IDX_W.
- IDX_W, 3, index width of out_idx.

Ports:
- clk       input   1      rising-edge clock
- rst       input   1      synchronous reset, active-high
- req       input   8      request strobes, any number may be high in a cycle
- out_idx   output  3      index of the presented request
- out_valid output  1      out_idx is valid
- out_ready input   1      consumer accepts out_idx this cycle
- pending   output  8      registered pending-request vector
- pend_cnt  output  4      popcount of pending (0..8)
- ovf       output  1      sticky overflow: a request merged into an already-pending bit

Behaviour:
- The design has one clock. Reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset, sampled at the clock edge with rst=1, produces:
  - pending=0, pend_cnt=0
  - out_valid=0, out_idx=0
  - ovf=0
  - RR pointer=7
- rst dominates all other inputs in that cycle, including any handshake in flight; the presented index is discarded.

Handshake:
- hs = out_valid & out_ready.
- load = (!out_valid | out_ready) & (pending != 0).
- On load, the selected bit s is removed from pending and registered: out_idx<=s, out_valid<=1.
- If hs and no load: out_valid<=0, out_idx holds its last value.
- While out_valid=1 and out_ready=0, out_idx and out_valid must hold stable.

Pending update:
- load_mask = onehot(s) if load, else 0.
- pending <= (pending & ~load_mask) | req.
- Selection uses registered pending only, never same-cycle req.

Latency:
- req bit at edge N gives pending bit after edge N.
- out_valid after edge N+1 if the output slot is free (2 cycles).
- Back-to-back throughput: 1 index per cycle while out_ready=1 and pending!=0.

Overflow and simultaneous events:
- ovf <= ovf | |(req & pending & ~load_mask).
- Cleared only by reset.
- A req on the bit being loaded in the same cycle re-arms that bit with no ovf.
- A req on the bit currently held in out_idx re-arms pending with no ovf.

Arbitration without the macro: fixed priority, highest index wins (bit 7 > ... > bit 0).

pend_cnt: registered popcount of the next pending value, so it always matches pending.

Optional Feature:
- Macro: REQ_RR_ARB_EN.
- Defined:
  - Round-robin arbitration.
  - A 3-bit pointer ptr holds the last loaded index, updated on every load.
  - Search order is ptr+1, ptr+2, ... wrapping mod 8; the first pending bit wins.
  - ptr=7 after reset, so the first search starts at bit 0.
- Not defined:
  - Fixed priority as above.
  - No pointer register.

Test Plan:
- Reset: apply rst with req=8'hFF, then deassert rst with req=0 → pending=0, out_valid=0, ovf=0, pend_cnt=0.
- Single request, fixed priority: req=8'b0000_0100 for 1 cycle, out_ready=1 → pending=8'h04 after 1 edge; out_valid=1, out_idx=2 after 2 edges; pending=0; the cycle after, out_valid=0.
- Multiple requests, fixed priority: req=8'hA5 for 1 cycle, out_ready=1 → out_idx sequence 7,5,2,0 on consecutive cycles; pend_cnt 4,3,2,1,0.
- Backpressure: pending=8'h81, out_ready=0 for 5 cycles → out_idx=7 held with out_valid=1 throughout; pending=8'h01; after out_ready=1, out_idx=0 next.
- Overflow and re-arm: req=8'h08 twice, 1 cycle apart, out_ready=0 with the slot holding 3 → second strobe sets pending[3], no ovf. A third req=8'h08 while pending[3]=1 → ovf=1, pending unchanged.
- REQ_RR_ARB_EN: keep req=8'hA5 asserted every cycle, out_ready=1 → out_idx sequence 0,2,5,7,0,2,... and ovf=1 after the first re-hit of a still-pending bit.
